// File: rtl/multi_colour_detect.sv
// Dominant-colour detector: two-stage overlay pipeline plus per-frame
// red/green/blue pixel counters driven by sop/eop framing.
module multi_colour_detect #(
    parameter int CW    = 4,
    parameter int CNT_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3*CW-1:0]   data_in,
    input  logic              valid_in,
    input  logic              sop,
    input  logic              eop,
    input  logic [CW-1:0]     upper_thresh,
    input  logic [CW-1:0]     margin,
    input  logic [1:0]        colour,
    output logic [3*CW-1:0]   data_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  colour_pixels,
    output logic [CNT_W-1:0]  count_r,
    output logic [CNT_W-1:0]  count_g,
    output logic [CNT_W-1:0]  count_b,
    output logic              frame_done,
    output logic              frame_abort
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [CW-1:0] ONES = {CW{1'b1}};
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};

    logic [CW-1:0] in_r, in_g, in_b;
    logic [CW:0]   lim_r, lim_g, lim_b;
    logic          det_r, det_g, det_b;

    logic [3*CW-1:0] s1_pix;
    logic [2:0]      s1_det;
    logic            s1_valid, s1_sop, s1_eop;
    logic [1:0]      s1_colour;

    logic [3*CW-1:0] overlay;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] run_r, run_g, run_b;
    logic [CNT_W-1:0] run_r_nxt, run_g_nxt, run_b_nxt;
    logic            latch, done_nxt, abort_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c,
        input logic             f
    );
        if (f && (c != {CNT_W{1'b1}}))
            return c + CNT_W'(1);
        return c;
    endfunction

    // Comparisons at CW+1 bits so channel+margin cannot wrap
    assign {in_r, in_g, in_b} = data_in;
    assign lim_r = {1'b0, in_r} + {1'b0, margin};
    assign lim_g = {1'b0, in_g} + {1'b0, margin};
    assign lim_b = {1'b0, in_b} + {1'b0, margin};

    assign det_r = (in_r >= upper_thresh) &&
                   ({1'b0, in_r} > lim_g) && ({1'b0, in_r} > lim_b);
    assign det_g = (in_g >= upper_thresh) &&
                   ({1'b0, in_g} > lim_r) && ({1'b0, in_g} > lim_b);
    assign det_b = (in_b >= upper_thresh) &&
                   ({1'b0, in_b} > lim_r) && ({1'b0, in_b} > lim_g);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_pix    <= '0;
            s1_det    <= '0;
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_colour <= '0;
        end else begin
            s1_pix    <= data_in;
            s1_det    <= {det_r, det_g, det_b};
            s1_valid  <= valid_in;
            s1_sop    <= valid_in & sop;
            s1_eop    <= valid_in & eop;
            s1_colour <= colour;
        end
    end

    always_comb begin
        overlay = '0;
        unique case (s1_colour)
            2'b00: if (s1_det[2]) overlay = {ONES, ZERO, ZERO};
            2'b01: if (s1_det[1]) overlay = {ZERO, ONES, ZERO};
            2'b10: if (s1_det[0]) overlay = {ZERO, ZERO, ONES};
            default: overlay = s1_pix;
        endcase
    end

    always_comb begin
        state_nxt = state;
        run_r_nxt = run_r;
        run_g_nxt = run_g;
        run_b_nxt = run_b;
        latch     = 1'b0;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        if (s1_valid) begin
            if (s1_sop) begin
                run_r_nxt = CNT_W'(s1_det[2]);
                run_g_nxt = CNT_W'(s1_det[1]);
                run_b_nxt = CNT_W'(s1_det[0]);
                abort_nxt = (state == ACTIVE);
                state_nxt = ACTIVE;
            end else if (state == ACTIVE) begin
                run_r_nxt = sat_inc(run_r, s1_det[2]);
                run_g_nxt = sat_inc(run_g, s1_det[1]);
                run_b_nxt = sat_inc(run_b, s1_det[0]);
            end
            // eop closes a frame only if one is open (or opens on this beat)
            if (s1_eop && (s1_sop || state == ACTIVE)) begin
                latch     = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            run_r       <= '0;
            run_g       <= '0;
            run_b       <= '0;
            count_r     <= '0;
            count_g     <= '0;
            count_b     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
        end else begin
            state       <= state_nxt;
            run_r       <= run_r_nxt;
            run_g       <= run_g_nxt;
            run_b       <= run_b_nxt;
            if (latch) begin
                count_r <= run_r_nxt;
                count_g <= run_g_nxt;
                count_b <= run_b_nxt;
            end
            frame_done  <= done_nxt;
            frame_abort <= abort_nxt;
            data_out    <= overlay;
            valid_out   <= s1_valid;
        end
    end

    always_comb begin
        colour_pixels = '0;
        unique case (colour)
            2'b00:   colour_pixels = run_r;
            2'b01:   colour_pixels = run_g;
            2'b10:   colour_pixels = run_b;
            default: colour_pixels = '0;
        endcase
    end

endmodule

// File: tb/tb_multi_colour_detect.sv
// Scoreboard bench for multi_colour_detect: directed pixels, queued
// expectations, monitor pops on valid_out. Second instance has CNT_W=3.
module tb_multi_colour_detect;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] data_in;
    logic        valid_in, sop, eop;
    logic [3:0]  upper_thresh, margin;
    logic [1:0]  colour;

    logic [11:0] data_out;
    logic        valid_out, frame_done, frame_abort;
    logic [16:0] colour_pixels, count_r, count_g, count_b;

    logic [11:0] s_data_out;
    logic        s_valid_out, s_frame_done, s_frame_abort;
    logic [2:0]  s_colour_pixels, s_count_r, s_count_g, s_count_b;

    always #5 clk = ~clk;

    multi_colour_detect u_dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .valid_in(valid_in), .sop(sop), .eop(eop),
        .upper_thresh(upper_thresh), .margin(margin),
        .colour(colour), .data_out(data_out),
        .valid_out(valid_out), .colour_pixels(colour_pixels),
        .count_r(count_r), .count_g(count_g), .count_b(count_b),
        .frame_done(frame_done), .frame_abort(frame_abort)
    );

    multi_colour_detect #(.CW(4), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .data_in(data_in),
        .valid_in(valid_in), .sop(sop), .eop(eop),
        .upper_thresh(upper_thresh), .margin(margin),
        .colour(colour), .data_out(s_data_out),
        .valid_out(s_valid_out), .colour_pixels(s_colour_pixels),
        .count_r(s_count_r), .count_g(s_count_g), .count_b(s_count_b),
        .frame_done(s_frame_done), .frame_abort(s_frame_abort)
    );

    typedef struct {
        logic [11:0] d;
        logic        done;
        logic        abort;
        int          r, g, b;
        int          sr, sg, sb;
        int          t;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   er = 0, eg = 0, eb = 0;
    int   esr = 0, esg = 0, esb = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        total++;
        if (a === x) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, a, x);
    endtask

    task automatic beat(input logic [1:0] c, input logic [11:0] p,
                        input logic s, input logic e,
                        input logic [11:0] xd,
                        input logic xdone, input logic xab);
        exp_t x;
        @(posedge clk);
        #1;
        colour   = c;
        data_in  = p;
        sop      = s;
        eop      = e;
        valid_in = 1'b1;
        x.d = xd; x.done = xdone; x.abort = xab;
        x.r = er; x.g = eg; x.b = eb;
        x.sr = esr; x.sg = esg; x.sb = esb;
        x.t = cyc;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            sop      = 1'b0;
            eop      = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL spurious_valid: got data %0h expected none",
                             data_out);
                end else begin
                    me = q.pop_front();
                    chk("data_out", data_out, me.d);
                    chk("frame_done", frame_done, me.done);
                    chk("frame_abort", frame_abort, me.abort);
                    chk("count_r", count_r, me.r);
                    chk("count_g", count_g, me.g);
                    chk("count_b", count_b, me.b);
                    chk("latency", cyc - me.t, 2);
                    chk("sat_data_out", s_data_out, me.d);
                    chk("sat_frame_done", s_frame_done, me.done);
                    chk("sat_count_r", s_count_r, me.sr);
                    chk("sat_count_g", s_count_g, me.sg);
                    chk("sat_count_b", s_count_b, me.sb);
                end
            end else begin
                chk("idle_done", frame_done, 1'b0);
                chk("idle_abort", frame_abort, 1'b0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        data_in = '0; valid_in = 1'b0; sop = 1'b0; eop = 1'b0;
        upper_thresh = 4'd8; margin = 4'd0; colour = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_data_out", data_out, 12'h000);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_count_r", count_r, 0);
        chk("rst_colour_pixels", colour_pixels, 0);
        chk("rst_done", frame_done, 1'b0);
        mon_en = 1'b1;

        // unframed overlay, red select
        beat(2'b00, 12'hF00, 0, 0, 12'hF00, 0, 0);
        beat(2'b00, 12'h984, 0, 0, 12'hF00, 0, 0);
        beat(2'b00, 12'hB8A, 0, 0, 12'hF00, 0, 0);
        beat(2'b00, 12'h400, 0, 0, 12'h000, 0, 0);
        beat(2'b00, 12'h700, 0, 0, 12'h000, 0, 0);
        beat(2'b00, 12'h800, 0, 0, 12'hF00, 0, 0);
        beat(2'b00, 12'h880, 0, 0, 12'h000, 0, 0);
        idle(2);
        margin = 4'd3;
        beat(2'b00, 12'hB8A, 0, 0, 12'h000, 0, 0);
        beat(2'b01, 12'h0F0, 0, 0, 12'h0F0, 0, 0);
        idle(2);
        margin = 4'd0;

        // frame with varying overlay select
        beat(2'b00, 12'hF00, 1, 0, 12'hF00, 0, 0);
        beat(2'b01, 12'h0F0, 0, 0, 12'h0F0, 0, 0);
        beat(2'b10, 12'h00F, 0, 0, 12'h00F, 0, 0);
        beat(2'b11, 12'h0F0, 0, 0, 12'h0F0, 0, 0);
        idle(3);
        colour = 2'b00; #1 chk("live_r", colour_pixels, 1);
        colour = 2'b01; #1 chk("live_g", colour_pixels, 2);
        colour = 2'b10; #1 chk("live_b", colour_pixels, 1);
        colour = 2'b11; #1 chk("live_pass", colour_pixels, 0);
        er = 2; eg = 2; eb = 1; esr = 2; esg = 2; esb = 1;
        beat(2'b00, 12'hF00, 0, 1, 12'hF00, 1, 0);
        idle(2);

        // abandoned frame
        beat(2'b00, 12'hF00, 1, 0, 12'hF00, 0, 0);
        beat(2'b00, 12'hF00, 0, 0, 12'hF00, 0, 0);
        beat(2'b00, 12'hF00, 0, 0, 12'hF00, 0, 0);
        beat(2'b00, 12'hF00, 1, 0, 12'hF00, 0, 1);
        idle(3);
        colour = 2'b00; #1 chk("restart_r", colour_pixels, 1);
        er = 1; eg = 1; eb = 0; esr = 1; esg = 1; esb = 0;
        beat(2'b00, 12'h0F0, 0, 1, 12'h000, 1, 0);
        idle(2);

        // eop outside a frame is ignored
        beat(2'b00, 12'hF00, 0, 1, 12'hF00, 0, 0);
        idle(2);

        // one-pixel frame that also abandons an open frame
        beat(2'b00, 12'hF00, 1, 0, 12'hF00, 0, 0);
        er = 0; eg = 1; eb = 0; esr = 0; esg = 1; esb = 0;
        beat(2'b00, 12'h0F0, 1, 1, 12'h000, 1, 1);
        idle(2);

        // saturation on the narrow instance
        for (int i = 0; i < 9; i++)
            beat(2'b00, 12'hF00, (i == 0), 0, 12'hF00, 0, 0);
        idle(3);
        colour = 2'b00; #1;
        chk("live_r_9", colour_pixels, 9);
        chk("sat_live_r", s_colour_pixels, 7);
        er = 10; eg = 0; eb = 0; esr = 7; esg = 0; esb = 0;
        beat(2'b00, 12'hF00, 0, 1, 12'hF00, 1, 0);
        er = 0; esr = 0;
        beat(2'b00, 12'h000, 1, 1, 12'h000, 1, 0);
        idle(2);

        // reset mid-frame in passthrough
        beat(2'b11, 12'hF00, 1, 0, 12'hF00, 0, 0);
        beat(2'b11, 12'h0F0, 0, 0, 12'h0F0, 0, 0);
        idle(3);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_data_out", data_out, 12'h000);
        chk("rst2_valid_out", valid_out, 1'b0);
        chk("rst2_colour_pixels", colour_pixels, 0);
        chk("rst2_count_g", count_g, 0);
        colour = 2'b00; #1 chk("rst2_run_r", colour_pixels, 0);
        colour = 2'b01; #1 chk("rst2_run_g", colour_pixels, 0);
        beat(2'b11, 12'h5A3, 0, 0, 12'h5A3, 0, 0);
        beat(2'b11, 12'h789, 0, 1, 12'h789, 0, 0);
        idle(1);

        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_colour_detect.md
MULTI_COLOUR_DETECT -- requirements
Module: multi_colour_detect

Interface
REQ-001 The block SHALL have parameter CW, default 4, giving bits per colour channel; the pixel is {R,G,B}, 3*CW bits, R in the MSBs.
REQ-002 The block SHALL have parameter CNT_W, default 17, giving the width of every pixel counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge system clock.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: data_in  in  3*CW  pixel {R,G,B}.
REQ-007 Port: valid_in  in  1  data_in, sop and eop qualified this cycle (one beat).
REQ-008 Port: sop  in  1  first pixel of frame; meaningful only with valid_in.
REQ-009 Port: eop  in  1  last pixel of frame; meaningful only with valid_in.
REQ-010 Port: upper_thresh  in  CW  minimum channel value for detection.
REQ-011 Port: margin  in  CW  required lead of detected channel over both others.
REQ-012 Port: colour  in  2  overlay/live-count select: 00 red, 01 green, 10 blue, 11 passthrough.
REQ-013 Port: data_out  out  3*CW  overlay pixel.
REQ-014 Port: valid_out  out  1  data_out valid.
REQ-015 Port: colour_pixels  out  CNT_W  live running count of the selected colour in the current frame.
REQ-016 Port: count_r, count_g, count_b  out  CNT_W each  counts latched at the end of the last complete frame.
REQ-017 Port: frame_done  out  1  one-cycle pulse when count_r/g/b update.
REQ-018 Port: frame_abort  out  1  one-cycle pulse when a frame is abandoned by a new sop.

Function
REQ-019 Channel X SHALL be detected iff X >= upper_thresh and X > Y+margin and X > Z+margin for the other channels Y, Z, with additions evaluated at CW+1 bits (no wrap).
REQ-020 At most one channel SHALL be detected per pixel; with margin=0, ties SHALL detect nothing.
REQ-021 Pipeline: stage 1 SHALL register the pixel, the three detect flags, valid, sop and eop; stage 2 SHALL register data_out and valid_out; latency SHALL be 2 cycles, throughput 1 pixel/cycle, no back-pressure.
REQ-022 For colour 00/01/10, data_out SHALL be all ones in the selected channel field and zero elsewhere when that channel is detected, else all zeros; for colour 11, data_out SHALL equal the input pixel.
REQ-023 colour SHALL be sampled at stage 1 along with the pixel.
REQ-024 Frame FSM states SHALL be IDLE and ACTIVE, advanced by stage-1 beats.
REQ-025 A sop beat in either state SHALL load each running counter with its detect flag (0 or 1) and enter ACTIVE.
REQ-026 A sop beat in ACTIVE SHALL additionally pulse frame_abort and leave count_r/g/b unchanged.
REQ-027 A non-sop beat in ACTIVE SHALL add each detect flag to its running counter.
REQ-028 Running counters SHALL saturate at 2^CNT_W-1.
REQ-029 Beats in IDLE without sop SHALL NOT change any counter; data_out SHALL still be produced.
REQ-030 An eop beat in ACTIVE SHALL include that pixel, latch the running values into count_r/g/b, pulse frame_done in the same cycle that pixel's valid_out is high, and return to IDLE.
REQ-031 A beat with sop and eop together SHALL be a one-pixel frame: counters load, count_* latch, frame_done pulses, and frame_abort pulses if previously ACTIVE.
REQ-032 An eop beat in IDLE SHALL be ignored.
REQ-033 colour_pixels SHALL show the running counter selected by the current colour input; for colour 11 it SHALL be 0.

Reset
REQ-034 On reset, all pipeline registers, data_out, valid_out, running counters, count_r/g/b, frame_done and frame_abort SHALL be 0, and the FSM SHALL enter IDLE.
REQ-035 Reset mid-frame SHALL discard the frame with no frame_done or frame_abort pulse.

Verification
REQ-036 CW=4, thresh=8, margin=0, colour=00; pixels F00, 984, B8A, 400 -> data_out F00, F00, F00, 000 at latency 2.
REQ-037 Same settings, pixel B8A with margin=3 -> 000, because B+3=13>11.
REQ-038 Frame of sop+F00, 0F0, 00F, 0F0, eop+F00 -> count_r=2, count_g=2, count_b=1; frame_done is one cycle, aligned with the last valid_out.
REQ-039 Frame of 3 red pixels, then sop without eop -> frame_abort pulses, count_* stay at previous values, and colour_pixels restarts from 0 or 1.
REQ-040 CNT_W=3 with 10 red pixels in one frame -> count_r=7 (saturated); then a single sop+eop 000 beat -> all counts 0 and frame_done pulses.
REQ-041 Assert reset during an ACTIVE frame with colour=11 -> all outputs 0 the next cycle, no pulses, and passthrough data_out resumes 2 cycles after the first post-reset beat.
